// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues reads to a 1-cycle synchronous instruction memory
// and buffers returned words in order, using credits so an in-flight read always has a slot.
module fetch_queue #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    req_valid,
    input  logic [ADDR_WIDTH-1:0]   req_pc,
    output logic                    req_ready,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_instr,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic                    out_misalign,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] r_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc    [DEPTH];
    logic                  r_mis   [DEPTH];

    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_inflight_v;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;

    logic w_accept;
    logic w_write;
    logic w_pop;
    logic w_nonempty;

    // The in-flight read holds a credit, so count plus in-flight never exceeds DEPTH.
    assign req_ready  = rst && !flush && ((r_count + CW'(r_inflight_v)) < CW'(DEPTH));
    assign w_accept   = req_valid && req_ready;
    assign mem_rd_en  = w_accept;
    assign mem_addr   = req_pc;

    assign w_nonempty = (r_count != '0);
    assign w_write    = r_inflight_v && !flush;
    assign out_valid  = w_nonempty && !flush;
    assign w_pop      = out_valid && out_ready;

    assign out_instr    = w_nonempty ? r_instr[r_head] : '0;
    assign out_pc       = w_nonempty ? r_pc[r_head]    : '0;
    assign out_misalign = w_nonempty ? r_mis[r_head]   : 1'b0;
    assign count        = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
        end else if (flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_inflight_v <= 1'b0;
        end else begin
            if (w_write) begin
                assert (r_count < CW'(DEPTH));
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop)
                r_head <= r_head + PW'(1);
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_inflight_v <= w_accept;
            if (w_accept)
                r_inflight_pc <= req_pc;
        end
    end

    // Storage is never reset; the head outputs are gated while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_instr[r_tail] <= mem_rdata;
            r_pc[r_tail]    <= r_inflight_pc;
            r_mis[r_tail]   <= (r_inflight_pc[1:0] != 2'b00);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: synchronous memory model, in-order scoreboard and directed scenarios.
module tb_fetch_queue;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_pc = '0;
    logic          req_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_misalign;
    logic [2:0]    count;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
        logic          mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_acc;
    logic [AW-1:0] pc;

    fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_misalign(out_misalign), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return (a == 12'h004) ? 32'h0050_0093 : {8'hC3, a, 12'h5A5};
    endfunction

    // One-cycle synchronous instruction memory; junk when not read.
    always @(posedge clk)
        mem_rdata <= mem_rd_en ? instr_of(mem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at +1 after posedge, so the negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            if (flush) sb.delete();
            else begin
                if (out_valid && out_ready) begin
                    chk("sb_nonempty", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        mon_e = sb.pop_front();
                        chk("sb_pc", out_pc, mon_e.pc);
                        chk("sb_instr", out_instr, mon_e.instr);
                        chk("sb_mis", out_misalign, mon_e.mis);
                    end
                end
                if (req_valid && req_ready)
                    sb.push_back('{pc: req_pc, instr: instr_of(req_pc), mis: (req_pc[1:0] != 2'b00)});
            end
        end
    end

    always @(negedge rst) sb.delete();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset: everything gated even with a request offered
        req_valid = 1'b1;
        req_pc    = 12'h004;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_count", count, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_mis", out_misalign, 0);
        req_valid = 1'b0;
        #1 rst = 1'b1;
        step();

        // Single fetch, 2-cycle latency
        req_valid = 1'b1; req_pc = 12'h004;
        settle();
        chk("single_ready", req_ready, 1);
        chk("single_rd_en", mem_rd_en, 1);
        chk("single_addr", mem_addr, 12'h004);
        chk("single_valid_c0", out_valid, 0);
        step();
        req_valid = 1'b0;
        settle();
        chk("single_valid_c1", out_valid, 0);
        chk("single_count_c1", count, 0);
        step();
        settle();
        chk("single_valid_c2", out_valid, 1);
        chk("single_pc_c2", out_pc, 12'h004);
        chk("single_instr_c2", out_instr, 32'h0050_0093);
        chk("single_mis_c2", out_misalign, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        settle();
        chk("single_count_end", count, 0);
        chk("single_sb_end", sb.size(), 0);
        step();

        // Back-pressure fill: credits stop acceptance at DEPTH
        n_acc = 0; pc = 12'h000;
        req_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_pc = pc;
            settle();
            chk("fill_ready", req_ready, (c < 4));
            if (req_ready) begin
                n_acc++;
                pc = pc + 12'h004;
            end
            if (c == 5) chk("fill_count", count, 4);
            step();
        end
        chk("fill_accepted", n_acc, 4);
        req_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        settle();
        chk("fill_count_end", count, 0);
        chk("fill_sb_end", sb.size(), 0);
        step();

        // Streaming at one per cycle, pointers wrap
        req_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_pc = AW'(c * 4);
            settle();
            chk("stream_ready", req_ready, 1);
            chk("stream_cnt_le1", (count <= 1), 1);
            chk("stream_valid", out_valid, (c >= 2));
            if (c >= 2) chk("stream_pc", out_pc, AW'((c - 2) * 4));
            step();
        end
        req_valid = 1'b0;
        repeat (4) step();
        settle();
        chk("stream_count_end", count, 0);
        chk("stream_sb_end", sb.size(), 0);
        step();

        // Flush with three buffered and one in flight
        req_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_pc = AW'(12'h200 + c * 4);
            settle();
            chk("flush_fill_ready", req_ready, 1);
            step();
        end
        req_valid = 1'b0; flush = 1'b1;
        settle();
        chk("flush_count_pre", count, 3);
        chk("flush_valid_c0", out_valid, 0);
        chk("flush_ready_c0", req_ready, 0);
        chk("flush_rd_en_c0", mem_rd_en, 0);
        step();
        flush = 1'b0; req_valid = 1'b1; req_pc = 12'h100;
        settle();
        chk("flush_valid_c1", out_valid, 0);
        chk("flush_count_c1", count, 0);
        chk("flush_ready_c1", req_ready, 1);
        step();
        req_valid = 1'b0;
        settle();
        chk("flush_valid_c2", out_valid, 0);
        chk("flush_count_c2", count, 0);
        step();
        settle();
        chk("flush_valid_c3", out_valid, 1);
        chk("flush_pc_c3", out_pc, 12'h100);
        chk("flush_instr_c3", out_instr, instr_of(12'h100));
        chk("flush_count_c3", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        settle();
        chk("flush_count_end", count, 0);
        chk("flush_sb_end", sb.size(), 0);
        step();

        // Misaligned PC plus push/pop at count == DEPTH-1 with a fetch in flight
        req_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_pc = (c == 3) ? 12'h006 : AW'(12'h300 + c * 4);
            settle();
            chk("mis_fill_ready", req_ready, 1);
            if (c == 3) chk("mis_addr", mem_addr, 12'h006);
            step();
        end
        req_valid = 1'b0; out_ready = 1'b1;
        settle();
        chk("mis_count_c4", count, 3);
        chk("mis_pc_c4", out_pc, 12'h300);
        step();
        settle();
        chk("mis_count_pushpop", count, 3);
        chk("mis_pc_c5", out_pc, 12'h304);
        step();
        settle();
        chk("mis_count_c6", count, 2);
        chk("mis_pc_c6", out_pc, 12'h308);
        step();
        settle();
        chk("mis_pc_head", out_pc, 12'h006);
        chk("mis_flag", out_misalign, 1);
        chk("mis_count_c7", count, 1);
        step();
        settle();
        chk("mis_count_end", count, 0);
        chk("mis_sb_end", sb.size(), 0);
        out_ready = 1'b0;
        step();

        // Asynchronous reset mid-operation, then restart
        req_valid = 1'b1; out_ready = 1'b0;
        req_pc = 12'h400; step();
        req_pc = 12'h404; step();
        req_valid = 1'b0; step();
        settle();
        chk("arst_count_pre", count, 2);
        chk("arst_valid_pre", out_valid, 1);
        step();
        rst = 1'b0; req_valid = 1'b1; req_pc = 12'h000;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_rd_en", mem_rd_en, 0);
        chk("arst_out_pc", out_pc, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_ready_release", req_ready, 1);
        step();
        req_valid = 1'b0;
        settle();
        chk("arst_valid_c1", out_valid, 0);
        step();
        settle();
        chk("arst_valid_c2", out_valid, 1);
        chk("arst_pc_c2", out_pc, 12'h000);
        chk("arst_instr_c2", out_instr, instr_of(12'h000));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        settle();
        chk("arst_count_end", count, 0);
        chk("arst_sb_end", sb.size(), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
